// File: rtl/fetch_pipeline.sv
// -----------------------------------------------------------------------------
// fetch_pipeline
//
// This is the front end of a five-stage in-order pipeline. It holds the
// program counter and fetches from a combinational instruction memory. It
// carries the fetched instruction word through the reg-read, ALU, data-mem
// and reg-write stages, one register per stage. It also applies pc
// redirects for JMP, BEQ and BNE.
//
// Each stage register advances only when its bit in clk_sequence is set. A
// stage that is not enabled holds its value; the design never inserts a
// bubble on its own. A taken redirect overrides the fetch in the same cycle,
// so the reg-read stage keeps the branch/jump that caused the redirect.
//
// BEQ/BNE targets come from br_target. This register is computed in
// advance, while the branch sits in the reg-read stage and clk_sequence[1]
// is high. JMP targets come directly from ra_data.
//
// Ports
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   alive           in   1   run enable; low = synchronous restart
//                            (the counters hold)
//   clk_sequence    in   5   stage enables: [0] fetch, [1] reg-read,
//                            [2] ALU, [3] data-mem, [4] reg-write
//   pcsel           in   2   redirect request: 00 none, 01 BEQ, 10 JMP,
//                            11 BNE
//   ra_data         in  32   Ra value for the branch/jump in flight
//   imem_rdata      in  32   instruction word at imem_addr (same cycle)
//   imem_addr       out 32   current pc, word aligned
//   instruction_rfr out 32   instruction entering reg-read
//   instruction_alu out 32   instruction entering ALU
//   instruction_dm  out 32   instruction entering data-mem
//   instruction_rfw out 32   instruction entering reg-write
//   pc_rfr          out 32   address of instruction_rfr plus 4
//   fetch_count     out 32   saturating count of sequential fetches
//   redirect_count  out 32   saturating count of taken redirects
//
// Configuration
//   FETCH_PERF_EN   Define this macro to build the two performance counters.
//                   When it is not defined, fetch_count and redirect_count
//                   are tied to 0 and no counter flops are built.
// -----------------------------------------------------------------------------
module fetch_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alive,
  input  logic [4:0]  clk_sequence,
  input  logic [1:0]  pcsel,
  input  logic [31:0] ra_data,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction_rfr,
  output logic [31:0] instruction_alu,
  output logic [31:0] instruction_dm,
  output logic [31:0] instruction_rfw,
  output logic [31:0] pc_rfr,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);

  // ADD R31,R31,R31: the architectural no-op used as the reset contents of
  // every stage register.
  localparam logic [31:0] NOP       = 32'h83FF_F800;
  localparam logic [5:0]  OP_BEQ    = 6'h1D;
  localparam logic [5:0]  OP_BNE    = 6'h1E;
  localparam logic [31:0] PC_STRIDE = 32'd4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_BEQ  = 2'b01,
    SEL_JMP  = 2'b10,
    SEL_BNE  = 2'b11
  } pcsel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] pc;
  logic [31:0] br_target;

  // ---------------------------------------------------------------------------
  // Redirect decode
  // ---------------------------------------------------------------------------
  pcsel_e      sel;
  logic        ra_zero;
  logic        redirect_taken;
  logic [31:0] redirect_target;

  assign sel     = pcsel_e'(pcsel);
  assign ra_zero = (ra_data == 32'd0);

  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line. Without it, any path that misses an assignment infers a latch.
  always_comb begin
    redirect_taken  = 1'b0;
    redirect_target = br_target;
    unique case (sel)
      SEL_NONE: redirect_taken = 1'b0;
      SEL_BEQ:  redirect_taken = ra_zero;
      SEL_BNE:  redirect_taken = !ra_zero;
      SEL_JMP: begin
        redirect_taken  = 1'b1;
        redirect_target = {ra_data[31:2], 2'b00};
      end
      default:  redirect_taken = 1'b0;
    endcase
  end

  // A sequential fetch happens only when no redirect is taken. A not-taken
  // BEQ/BNE therefore looks exactly like an ordinary fetch.
  logic fetch_load;
  assign fetch_load = clk_sequence[0] && !redirect_taken;

  logic [31:0] pc_next_seq;
  assign pc_next_seq = pc + PC_STRIDE;   // wraps FFFF_FFFC -> 0 naturally

  // ---------------------------------------------------------------------------
  // Branch target precompute
  // The target is relative to the address after the branch (pc_rfr). The
  // 16-bit literal counts words, so it is sign-extended and scaled by 4.
  // ---------------------------------------------------------------------------
  logic        rfr_is_branch;
  logic [31:0] br_offset;
  logic [31:0] br_target_next;

  assign rfr_is_branch  = (instruction_rfr[31:26] == OP_BEQ) ||
                          (instruction_rfr[31:26] == OP_BNE);
  assign br_offset      = {{14{instruction_rfr[15]}}, instruction_rfr[15:0], 2'b00};
  assign br_target_next = pc_rfr + br_offset;

  // ---------------------------------------------------------------------------
  // Fetch stage: pc, instruction_rfr, pc_rfr, br_target
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every register in
  // the block samples pre-edge values. Blocking assignments here would let
  // one register see another's new value within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= 32'd0;
      pc_rfr          <= 32'd0;
      br_target       <= 32'd0;
      instruction_rfr <= NOP;
    end else if (!alive) begin
      pc              <= 32'd0;
      pc_rfr          <= 32'd0;
      br_target       <= 32'd0;
      instruction_rfr <= NOP;
    end else begin
      if (redirect_taken) begin
        // instruction_rfr and pc_rfr hold the branch/jump that redirected.
        pc <= redirect_target;
      end else if (fetch_load) begin
        pc              <= pc_next_seq;
        pc_rfr          <= pc_next_seq;
        instruction_rfr <= imem_rdata;
      end

      if (clk_sequence[1] && rfr_is_branch) begin
        br_target <= br_target_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Downstream stages. Each stage register holds when its enable is low.
  // Because all of them sample pre-edge values, several enables in the same
  // cycle produce a true shift.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_alu <= NOP;
      instruction_dm  <= NOP;
      instruction_rfw <= NOP;
    end else if (!alive) begin
      instruction_alu <= NOP;
      instruction_dm  <= NOP;
      instruction_rfw <= NOP;
    end else begin
      if (clk_sequence[1]) instruction_alu <= instruction_rfr;
      if (clk_sequence[2]) instruction_dm  <= instruction_alu;
      if (clk_sequence[3]) instruction_rfw <= instruction_dm;
    end
  end

  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // Performance counters. They saturate at all-ones and hold their value
  // through an alive=0 restart; only rst_n clears them.
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else if (alive) begin
      if (fetch_load && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_taken && (redirect_cnt_q != 32'hFFFF_FFFF))
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign fetch_count    = fetch_cnt_q;
  assign redirect_count = redirect_cnt_q;
`else
  assign fetch_count    = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule
